// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: req/ack single-port memory bus between the arbiter (master) and memory (slave)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and load/store onto one req/ack memory port
// Optional MEM_TIMEOUT_EN aborts accesses whose ack never arrives
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              ls_read_en,
    input  logic              ls_write_en,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_done,
    mem_port_arbiter_if.master mem,
    output logic              core_stall,
    output logic              bus_err
);
    typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;
    state_t state, state_d;
    logic ls_any, busy, expire, finish;
    assign ls_any = ls_read_en | ls_write_en;
    assign busy   = (state == FETCH) || (state == DATA);
    assign finish = busy && (mem.ack || expire);
    assign core_stall = (if_req & ~if_valid) | (ls_any & ~ls_done);
`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    assign expire = !mem.ack && (cnt == CW'(TIMEOUT));
    // Zero in the first request cycle since the previous cycle was IDLE
    always_ff @(posedge clk)
        if (rst) cnt <= '0;
        else     cnt <= busy ? cnt + 1'b1 : '0;
`else
    assign expire = 1'b0;
`endif
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = ls_any ? DATA : if_req ? FETCH : IDLE;
            RESP:    state_d = IDLE;
            default: state_d = finish ? RESP : state;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem.req   <= 1'b0;
            mem.we    <= 1'b0;
            mem.addr  <= '0;
            mem.wdata <= '0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
            if_valid  <= 1'b0;
            ls_done   <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state    <= state_d;
            if_valid <= 1'b0;
            ls_done  <= 1'b0;
            bus_err  <= 1'b0;
            if (state == IDLE && ls_any) begin
                mem.req   <= 1'b1;
                mem.we    <= ls_write_en;
                mem.addr  <= ls_addr;
                mem.wdata <= ls_wdata;
                bus_err   <= ls_read_en & ls_write_en;
            end else if (state == IDLE && if_req) begin
                mem.req  <= 1'b1;
                mem.we   <= 1'b0;
                mem.addr <= if_addr;
            end else if (finish) begin
                mem.req <= 1'b0;
                bus_err <= expire;
                if (state == FETCH) begin
                    if_valid <= 1'b1;
                    if_rdata <= mem.ack ? mem.rdata : DATA_W'(32'h0000_0013);
                end else begin
                    ls_done <= 1'b1;
                    if (!mem.we) ls_rdata <= mem.ack ? mem.rdata : '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors with hand-computed expectations for mem_port_arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        ls_read_en = 1'b0;
    logic        ls_write_en = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic [31:0] ls_rdata;
    logic        ls_done;
    logic        core_stall;
    logic        bus_err;
    int          n_chk = 0;
    int          n_err = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .ls_read_en(ls_read_en), .ls_write_en(ls_write_en), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_done(ls_done),
        .mem(bus.master), .core_stall(core_stall), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Enter the next cycle: inputs are driven 2 time units after the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        bus.ack   = 1'b0;
        bus.rdata = '0;
        repeat (3) tick();
        settle();
        check("rst_req", bus.req, 0);
        check("rst_we", bus.we, 0);
        check("rst_addr", bus.addr, 0);
        check("rst_valid", if_valid, 0);
        check("rst_done", ls_done, 0);
        check("rst_err", bus_err, 0);
        check("rst_stall", core_stall, 0);
        rst = 1'b0;

        // Zero-wait fetch
        tick(); if_req = 1'b1; if_addr = 32'h100; settle();
        check("f_c0_stall", core_stall, 1);
        check("f_c0_req", bus.req, 0);
        tick(); bus.ack = 1'b1; bus.rdata = 32'h0050_0093; settle();
        check("f_c1_req", bus.req, 1);
        check("f_c1_addr", bus.addr, 32'h100);
        check("f_c1_we", bus.we, 0);
        check("f_c1_stall", core_stall, 1);
        tick(); bus.ack = 1'b0; settle();
        check("f_c2_valid", if_valid, 1);
        check("f_c2_rdata", if_rdata, 32'h0050_0093);
        check("f_c2_stall", core_stall, 0);
        check("f_c2_req", bus.req, 0);
        if_req = 1'b0;
        tick(); settle();
        check("f_c3_valid", if_valid, 0);
        check("f_c3_req", bus.req, 0);

        // Load with 3 wait states
        tick(); ls_read_en = 1'b1; ls_addr = 32'h2000; settle();
        for (int i = 1; i <= 3; i++) begin
            tick(); settle();
            check($sformatf("l_c%0d_req", i), bus.req, 1);
            check($sformatf("l_c%0d_done", i), ls_done, 0);
        end
        tick(); bus.ack = 1'b1; bus.rdata = 32'hCAFE_F00D; settle();
        check("l_c4_req", bus.req, 1);
        check("l_c4_addr", bus.addr, 32'h2000);
        check("l_c4_we", bus.we, 0);
        tick(); bus.ack = 1'b0; settle();
        check("l_c5_done", ls_done, 1);
        check("l_c5_rdata", ls_rdata, 32'hCAFE_F00D);
        check("l_c5_req", bus.req, 0);
        check("l_c5_stall", core_stall, 0);
        ls_read_en = 1'b0;
        tick(); settle();
        check("l_c6_done", ls_done, 0);

        // Simultaneous store and fetch: store goes first
        tick(); if_req = 1'b1; if_addr = 32'h300; ls_write_en = 1'b1; ls_addr = 32'h40; ls_wdata = 32'h1234; settle();
        tick(); bus.ack = 1'b1; settle();
        check("s_c1_req", bus.req, 1);
        check("s_c1_we", bus.we, 1);
        check("s_c1_addr", bus.addr, 32'h40);
        check("s_c1_wdata", bus.wdata, 32'h1234);
        tick(); bus.ack = 1'b0; settle();
        check("s_c2_done", ls_done, 1);
        check("s_c2_valid", if_valid, 0);
        check("s_c2_rdata_kept", ls_rdata, 32'hCAFE_F00D);
        check("s_c2_stall", core_stall, 1);
        ls_write_en = 1'b0;
        tick(); settle();
        check("s_c3_req", bus.req, 0);
        tick(); bus.ack = 1'b1; bus.rdata = 32'h0000_0011; settle();
        check("s_c4_req", bus.req, 1);
        check("s_c4_we", bus.we, 0);
        check("s_c4_addr", bus.addr, 32'h300);
        tick(); bus.ack = 1'b0; settle();
        check("s_c5_valid", if_valid, 1);
        check("s_c5_rdata", if_rdata, 32'h0000_0011);
        if_req = 1'b0;
        tick(); settle();

        // Reset during a pending load; late ack ignored
        tick(); ls_read_en = 1'b1; ls_addr = 32'h80; settle();
        tick(); settle();
        check("r_c1_req", bus.req, 1);
        tick(); rst = 1'b1; ls_read_en = 1'b0; settle();
        tick(); rst = 1'b0; bus.ack = 1'b1; bus.rdata = 32'hDEAD_BEEF; settle();
        check("r_c3_req", bus.req, 0);
        check("r_c3_rdata", ls_rdata, 0);
        tick(); bus.ack = 1'b0; settle();
        check("r_c4_done", ls_done, 0);
        check("r_c4_req", bus.req, 0);
        check("r_c4_rdata", ls_rdata, 0);
        tick(); settle();
        check("r_c5_req", bus.req, 0);

        // Read/write conflict: treated as write, bus_err with mem_req
        tick(); ls_read_en = 1'b1; ls_write_en = 1'b1; ls_addr = 32'h44; ls_wdata = 32'h55; settle();
        check("c_c0_err", bus_err, 0);
        tick(); settle();
        check("c_c1_err", bus_err, 1);
        check("c_c1_we", bus.we, 1);
        check("c_c1_req", bus.req, 1);
        tick(); bus.ack = 1'b1; settle();
        check("c_c2_err", bus_err, 0);
        check("c_c2_req", bus.req, 1);
        tick(); bus.ack = 1'b0; settle();
        check("c_c3_done", ls_done, 1);
        check("c_c3_err", bus_err, 0);
        ls_read_en = 1'b0; ls_write_en = 1'b0;
        tick(); settle();

`ifdef MEM_TIMEOUT_EN
        // Fetch with no ack aborts after 15 wait cycles
        tick(); if_req = 1'b1; if_addr = 32'h500; settle();
        for (int i = 1; i <= 16; i++) begin
            tick(); settle();
            check($sformatf("t_c%0d_req", i), bus.req, 1);
        end
        tick(); settle();
        check("t_c17_req", bus.req, 0);
        check("t_c17_valid", if_valid, 1);
        check("t_c17_rdata", if_rdata, 32'h0000_0013);
        check("t_c17_err", bus_err, 1);
        if_req = 1'b0;
        tick(); settle();
        check("t_c18_err", bus_err, 0);
`else
        // Long wait is unbounded without the timeout
        tick(); ls_read_en = 1'b1; ls_addr = 32'h600; settle();
        for (int i = 1; i <= 20; i++) begin
            tick(); settle();
            check($sformatf("w_c%0d_req", i), bus.req, 1);
            check($sformatf("w_c%0d_err", i), bus_err, 0);
        end
        tick(); bus.ack = 1'b1; bus.rdata = 32'h0BAD_F00D; settle();
        tick(); bus.ack = 1'b0; settle();
        check("w_done", ls_done, 1);
        check("w_rdata", ls_rdata, 32'h0BAD_F00D);
        check("w_err", bus_err, 0);
        ls_read_en = 1'b0;
        tick(); settle();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between instruction fetch and the load/store path of the RISC-V core. Load/store requests are qualified by mem_read_en/mem_write_en from the control unit. The block serialises the two requesters onto a variable-latency req/ack memory port and returns per-requester completion pulses. It also drives core_stall, which freezes PC and register-file writes while an access is outstanding.

Parameters:
ADDR_W, 32, address width of all address ports
DATA_W, 32, data width of all data ports
TIMEOUT, 15, maximum wait cycles for mem_ack; used only with MEM_TIMEOUT_EN

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
if_req  in  1  fetch request, level, held until if_valid
if_addr  in  ADDR_W  fetch address (PC)
if_rdata  out  DATA_W  fetched instruction, registered
if_valid  out  1  one-cycle fetch completion pulse
ls_read_en  in  1  load request (control-unit mem_read_en), level
ls_write_en  in  1  store request (control-unit mem_write_en), level
ls_addr  in  ADDR_W  ALU-computed data address
ls_wdata  in  DATA_W  store data
ls_rdata  out  DATA_W  load data, registered
ls_done  out  1  one-cycle load/store completion pulse
mem_req  out  1  memory request, registered, held until ack
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  one-cycle completion from memory
core_stall  out  1  combinational stall to PC / regfile
bus_err  out  1  one-cycle error pulse

Behaviour:
- Reset: state=IDLE. All registered outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, if_rdata, ls_rdata, if_valid, ls_done, bus_err. Reset mid-access aborts it: mem_req drops on the next edge, and a late mem_ack is ignored.
- FSM states: IDLE, FETCH, DATA, RESP.
- IDLE: requests are sampled here only. Priority is load/store over fetch.
  - If ls_read_en|ls_write_en: go to DATA. Latch ls_addr into mem_addr and ls_wdata into mem_wdata. Set mem_we=ls_write_en, mem_req=1.
  - Else if if_req: go to FETCH. Latch if_addr into mem_addr. Set mem_we=0, mem_req=1.
  - Else stay in IDLE.
- FETCH/DATA: mem_addr, mem_we and mem_wdata stay stable while mem_req=1. mem_ack is sampled on each edge.
  - On ack, mem_req goes to 0 and the state goes to RESP.
  - For a fetch, capture mem_rdata into if_rdata and set if_valid=1.
  - For a load, capture mem_rdata into ls_rdata and set ls_done=1.
  - For a store, set ls_done=1; ls_rdata is unchanged.
- RESP: the pulse is high for exactly one cycle, then the state unconditionally returns to IDLE with the pulse cleared. Requests are not sampled in RESP. The requester updates on the edge that ends RESP, so no access is reissued.
- mem_ack in IDLE or RESP is ignored.
- Latency: request in cycle 0, mem_req in cycle 1, ack in cycle N≥1, pulse in cycle N+1, IDLE in cycle N+2. With a zero-wait memory (ack in cycle 1), a fetch takes 3 cycles; back-to-back accesses are allowed.
- ls_read_en and ls_write_en both high in IDLE: the access is treated as a write, and bus_err pulses one cycle together with mem_req assertion.
- core_stall = (if_req & ~if_valid) | ((ls_read_en|ls_write_en) & ~ls_done). It is low in the completion cycle so the core advances on that edge.
- Requests dropped early by the requester do not cancel an access already issued; it completes normally.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A counter of width clog2(TIMEOUT+1) clears on entry to FETCH/DATA and increments each cycle without ack.
  - When the counter reaches TIMEOUT with no ack, the access aborts: mem_req=0 and the FSM goes to RESP. The requester's pulse is issued with read data 32'h0000_0013 (NOP) for fetch, or 0 for load, and bus_err pulses in the same cycle.
  - An ack in the abort cycle wins over the timeout.
- Not defined: no counter exists, waits are unbounded, bus_err is driven only by the read/write conflict, and TIMEOUT is unused.

Test Plan:
- Zero-wait fetch: if_req=1, if_addr=0x100, mem_ack in cycle 1 with rdata=0x00500093 -> mem_addr=0x100, mem_we=0; if_valid in cycle 2 with if_rdata=0x00500093; core_stall=1 in cycles 0-1 and 0 in cycle 2.
- Load with 3 wait states: ls_read_en=1, ls_addr=0x2000, ack in cycle 4 with rdata=0xCAFEF00D -> mem_req high in cycles 1-4; ls_done in cycle 5 with ls_rdata=0xCAFEF00D.
- Simultaneous: if_req=1 and ls_write_en=1 with ls_addr=0x40, ls_wdata=0x1234 -> store issued first with mem_we=1 and mem_wdata=0x1234; fetch issued after RESP/IDLE; if_valid follows ls_done by at least 3 cycles.
- Reset mid-wait: rst=1 in cycle 2 of a DATA access, ack in cycle 3 -> mem_req=0 from cycle 3; no ls_done; state IDLE.
- Conflict: ls_read_en=ls_write_en=1 -> bus_err pulse for 1 cycle; mem_we=1.
- MEM_TIMEOUT_EN, TIMEOUT=15, fetch with no ack -> mem_req drops after 15 wait cycles; if_valid=1, if_rdata=0x00000013 and bus_err=1 in the same cycle.
